// File: rtl/dehaze_ram_sched_if.sv
// Control, display, core-stream and frame-RAM signals of the dehaze RAM scheduler.
// master = scheduler side, slave = surrounding logic.
interface dehaze_ram_sched_if #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 16
);
  logic              start;
  logic              switch_ram;
  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic              disp_valid;
  logic [DATA_W-1:0] disp_data;
  logic              src_valid;
  logic              src_ready;
  logic [DATA_W-1:0] src_data;
  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_data;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              busy;
  logic              done;

  modport master (
    input  start, switch_ram, disp_req, disp_addr,
    input  src_ready, res_valid, res_data, ram_rdata,
    output disp_valid, disp_data, src_valid, src_data,
    output res_ready, ram_en, ram_we, ram_addr, ram_wdata,
    output busy, done
  );

  modport slave (
    output start, switch_ram, disp_req, disp_addr,
    output src_ready, res_valid, res_data, ram_rdata,
    input  disp_valid, disp_data, src_valid, src_data,
    input  res_ready, ram_en, ram_we, ram_addr, ram_wdata,
    input  busy, done
  );
endinterface

// File: rtl/dehaze_ram_sched.sv
// Single-port frame-RAM scheduler for one dehaze pass.
// Port priority per cycle: display, then result write, then source read.
module dehaze_ram_sched #(
  parameter int ADDR_W     = 18,
  parameter int DATA_W     = 16,
  parameter int PIX_NUM    = 129600,
  parameter int FIFO_DEPTH = 4
) (
  input logic clk,
  input logic rst,
  dehaze_ram_sched_if.master bus
);

  localparam int FW = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] PIX = ADDR_W'(PIX_NUM);

  typedef enum logic [1:0] {
    S_IDLE, S_RUN, S_DRAIN, S_DONE
  } state_t;

  state_t r_state, w_nxt;

  logic              r_start_d;
  logic [ADDR_W-1:0] r_rd_cnt;
  logic [ADDR_W-1:0] r_wr_cnt;
  logic [ADDR_W-1:0] r_acc_cnt;

  logic [DATA_W-1:0] r_ff [FIFO_DEPTH];
  logic [FW:0]       r_ff_wp;
  logic [FW:0]       r_ff_rp;

  logic [DATA_W-1:0] r_sk [2];
  logic              r_sk_wp;
  logic              r_sk_rp;
  logic [1:0]        r_sk_cnt;

  logic r_core_tag;
  logic r_disp_tag;

  logic w_act, w_edge, w_disp;
  logic w_ff_empty, w_ff_full;
  logic w_res_ready, w_push_res;
  logic w_wr, w_rd, w_credit;
  logic w_sk_ne, w_sk_push, w_sk_pop;
  logic w_src_valid;
  logic [DATA_W-1:0] w_src_data;

  assign w_act  = (r_state == S_RUN) | (r_state == S_DRAIN);
  assign w_edge = bus.start & ~r_start_d;
  assign w_disp = bus.disp_req & ~rst;

  assign w_ff_empty = (r_ff_wp == r_ff_rp);
  assign w_ff_full  = (r_ff_wp[FW] != r_ff_rp[FW]) &&
                      (r_ff_wp[FW-1:0] == r_ff_rp[FW-1:0]);

  assign w_res_ready = w_act & ~w_ff_full & (r_acc_cnt < PIX);
  assign w_push_res  = bus.res_valid & w_res_ready;

  assign w_wr = ~w_ff_empty & ~w_disp & w_act;

  // Occupancy plus the read still in flight must stay below the skid size
  assign w_credit = (r_sk_cnt + {1'b0, r_core_tag}) < 2'd2;

  assign w_rd = (r_state == S_RUN) & ~w_disp & ~w_wr &
                (r_rd_cnt < PIX) & w_credit;

  // Returning read data bypasses an empty skid straight to the core
  assign w_sk_ne     = (r_sk_cnt != 2'd0);
  assign w_src_valid = w_sk_ne | r_core_tag;
  assign w_src_data  = w_sk_ne    ? r_sk[r_sk_rp] :
                       r_core_tag ? bus.ram_rdata : '0;
  assign w_sk_push   = r_core_tag & (w_sk_ne | ~bus.src_ready);
  assign w_sk_pop    = w_sk_ne & bus.src_ready;

  assign bus.src_valid  = w_src_valid;
  assign bus.src_data   = w_src_data;
  assign bus.res_ready  = w_res_ready;
  assign bus.disp_valid = r_disp_tag;
  assign bus.disp_data  = r_disp_tag ? bus.ram_rdata : '0;
  assign bus.busy       = w_act;
  assign bus.done       = (r_state == S_DONE);

  always_comb begin
    bus.ram_en    = 1'b0;
    bus.ram_we    = 1'b0;
    bus.ram_addr  = '0;
    bus.ram_wdata = '0;
    if (w_disp) begin
      bus.ram_en   = 1'b1;
      bus.ram_addr = bus.disp_addr + (bus.switch_ram ? PIX : '0);
    end else if (w_wr) begin
      bus.ram_en    = 1'b1;
      bus.ram_we    = 1'b1;
      bus.ram_addr  = PIX + r_wr_cnt;
      bus.ram_wdata = r_ff[r_ff_rp[FW-1:0]];
    end else if (w_rd) begin
      bus.ram_en   = 1'b1;
      bus.ram_addr = r_rd_cnt;
    end
  end

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (w_edge) w_nxt = S_RUN;
      S_RUN:   if (r_rd_cnt == PIX) w_nxt = S_DRAIN;
      S_DRAIN: if (r_wr_cnt == PIX) w_nxt = S_DONE;
      S_DONE:  w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_start_d  <= 1'b0;
      r_rd_cnt   <= '0;
      r_wr_cnt   <= '0;
      r_acc_cnt  <= '0;
      r_ff_wp    <= '0;
      r_ff_rp    <= '0;
      r_sk_wp    <= 1'b0;
      r_sk_rp    <= 1'b0;
      r_sk_cnt   <= 2'd0;
      r_core_tag <= 1'b0;
      r_disp_tag <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_ff[i] <= '0;
      for (int i = 0; i < 2; i++) r_sk[i] <= '0;
    end else begin
      r_state    <= w_nxt;
      r_start_d  <= bus.start;
      r_core_tag <= w_rd;
      r_disp_tag <= w_disp;
      if ((r_state == S_IDLE) && w_edge) begin
        r_rd_cnt  <= '0;
        r_wr_cnt  <= '0;
        r_acc_cnt <= '0;
      end else begin
        if (w_rd)       r_rd_cnt  <= r_rd_cnt + 1'b1;
        if (w_wr)       r_wr_cnt  <= r_wr_cnt + 1'b1;
        if (w_push_res) r_acc_cnt <= r_acc_cnt + 1'b1;
      end
      if (w_push_res) begin
        r_ff[r_ff_wp[FW-1:0]] <= bus.res_data;
        r_ff_wp <= r_ff_wp + 1'b1;
      end
      if (w_wr) r_ff_rp <= r_ff_rp + 1'b1;
      if (w_sk_push) begin
        r_sk[r_sk_wp] <= bus.ram_rdata;
        r_sk_wp <= ~r_sk_wp;
      end
      if (w_sk_pop) r_sk_rp <= ~r_sk_rp;
      r_sk_cnt <= r_sk_cnt + {1'b0, w_sk_push} - {1'b0, w_sk_pop};
    end
  end

endmodule

// File: tb/tb_dehaze_ram_sched.sv
// Scoreboard bench for dehaze_ram_sched with an 8-pixel frame.
// Models the frame RAM and an identity dehaze core.
module tb_dehaze_ram_sched;

  localparam int AW = 5;
  localparam int DW = 16;
  localparam int PN = 8;

  logic clk = 1'b0;
  logic rst;

  dehaze_ram_sched_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  dehaze_ram_sched #(
    .ADDR_W(AW), .DATA_W(DW), .PIX_NUM(PN), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  logic [63:0] wexp_q[$];
  logic [DW-1:0] dq[$];
  logic [DW-1:0] core_q[$];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Frame RAM: one-cycle read latency, region 0 preloaded with 10..17
  logic [DW-1:0] mem [2*PN];
  bit mem_init = 1'b0;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 2*PN; i++)
        mem[i] <= (i < PN) ? DW'(10 + i) : '0;
      mem_init <= 1'b1;
    end else if (bus.ram_en) begin
      if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
      else bus.ram_rdata <= mem[bus.ram_addr];
    end
  end

  // Identity core with optional backpressure, result hold-off and a 9th result
  bit bp_en = 1'b0;
  bit extra_en = 1'b0;
  int hold_start = -100;
  int emitted = 0;
  bit tgl = 1'b0;
  bit hold;
  always @(posedge clk) begin
    if (rst) begin
      core_q.delete();
      emitted = 0;
    end else begin
      if (bus.res_valid && bus.res_ready) begin
        if (core_q.size() > 0) void'(core_q.pop_front());
        emitted++;
      end
      if (bus.src_valid && bus.src_ready) core_q.push_back(bus.src_data);
      if (!bus.busy) emitted = 0;
    end
    #1;
    tgl = ~tgl;
    bus.src_ready = bp_en ? tgl : 1'b1;
    hold = (cyc >= hold_start) && (cyc < hold_start + 6);
    bus.res_valid = (core_q.size() > 0 && !hold) ||
                    (extra_en && emitted >= PN);
    bus.res_data = (core_q.size() > 0) ? core_q[0] : 16'hDEAD;
  end

  int rd_iss = 0;
  int src_acc = 0;
  int res_acc = 0;
  int wr_tot = 0;
  int done_cnt = 0;
  bit prev_dreq = 1'b0;
  int occ;
  logic [63:0] e;
  logic [AW-1:0] da;

  always @(negedge clk) begin
    if (rst) begin
      rd_iss = 0; src_acc = 0; res_acc = 0; wr_tot = 0;
      prev_dreq = 1'b0;
    end else begin
      occ = res_acc - wr_tot;
      if (bus.busy) chk("fifo_occ", 64'(occ <= 4), 1);
      if (occ == 4 && bus.res_valid) chk("rdy_full", bus.res_ready, 0);
      if (bus.res_valid && res_acc >= PN)
        chk("rdy_9th", bus.res_ready, 0);
      if (bus.disp_req) begin
        da = bus.disp_addr + (bus.switch_ram ? AW'(PN) : AW'(0));
        chk("disp_acc", {bus.ram_en, bus.ram_we, bus.ram_addr},
            {2'b10, da});
      end else if (bus.ram_en && bus.ram_we) begin
        if (wexp_q.size() == 0) chk("wr_extra", wexp_q.size(), 1);
        else begin
          e = wexp_q.pop_front();
          chk("wr", {bus.ram_addr, bus.ram_wdata}, e);
        end
        wr_tot++;
      end else if (bus.ram_en) begin
        chk("rd_addr", bus.ram_addr, rd_iss);
        rd_iss++;
        chk("rd_credit", 64'(rd_iss - src_acc <= 2), 1);
      end
      if (bus.disp_valid || prev_dreq)
        chk("disp_vld", bus.disp_valid, prev_dreq);
      if (bus.disp_valid && dq.size() > 0)
        chk("disp_data", bus.disp_data, dq.pop_front());
      if (bus.src_valid && bus.src_ready) src_acc++;
      if (bus.res_valid && bus.res_ready) res_acc++;
      if (bus.done) begin
        done_cnt++;
        chk("done_busy", bus.busy, 0);
      end
      if (!bus.busy) begin
        rd_iss = 0; src_acc = 0; res_acc = 0; wr_tot = 0;
      end
      prev_dreq = bus.disp_req;
    end
  end

  int d0 = 0;

  task automatic push_wexp();
    for (int i = 0; i < PN; i++)
      wexp_q.push_back({43'd0, AW'(PN + i), DW'(10 + i)});
  endtask

  task automatic start_pass();
    @(posedge clk); #1 bus.start = 1'b0;
    push_wexp();
    d0 = done_cnt;
    @(posedge clk); #1 bus.start = 1'b1;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!bus.done && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_to"}, 64'(n < 400), 1);
    repeat (3) @(negedge clk);
    chk({tag, "_done1"}, 64'(done_cnt - d0), 1);
    chk({tag, "_idle"}, bus.busy, 0);
    chk({tag, "_wrleft"}, wexp_q.size(), 0);
  endtask

  task automatic disp(input int a, input bit sw, input int n,
                      input int exp);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      bus.disp_req = 1'b1;
      bus.disp_addr = AW'(a);
      bus.switch_ram = sw;
      dq.push_back(DW'(exp));
    end
    @(posedge clk); #1 bus.disp_req = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1;
    bus.start = 1'b1;
    bus.switch_ram = 1'b0;
    bus.disp_req = 1'b0;
    bus.disp_addr = '0;
    bus.ram_rdata = '0;
    bus.src_ready = 1'b1;
    bus.res_valid = 1'b0;
    bus.res_data = '0;

    repeat (3) begin
      @(negedge clk);
      chk("rst_outs", {bus.disp_valid, bus.disp_data, bus.src_valid,
          bus.src_data, bus.res_ready, bus.ram_en, bus.ram_we,
          bus.ram_addr, bus.ram_wdata, bus.busy, bus.done}, 0);
    end
    push_wexp();
    d0 = done_cnt;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("busy_pre", bus.busy, 0);
    @(negedge clk);
    chk("busy_rise", bus.busy, 1);
    wait_done("full");

    start_pass();
    repeat (6) @(posedge clk);
    disp(3, 1'b1, 5, 13);
    wait_done("disp");

    bp_en = 1'b1;
    start_pass();
    @(posedge clk); #1 hold_start = cyc;
    repeat (8) @(posedge clk);
    disp(0, 1'b0, 8, 10);
    wait_done("bp");
    bp_en = 1'b0;

    extra_en = 1'b1;
    start_pass();
    repeat (4) @(posedge clk);
    #1 bus.start = 1'b0;
    @(posedge clk); #1 bus.start = 1'b1;
    wait_done("ign");
    extra_en = 1'b0;
    repeat (10) @(negedge clk);
    chk("ign_norestart", bus.busy, 0);

    start_pass();
    n = 0;
    while (rd_iss < 4 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("mid_reach", 64'(n < 200), 1);
    @(posedge clk); #1;
    rst = 1'b1;
    bus.start = 1'b0;
    wexp_q.delete();
    d0 = done_cnt;
    repeat (2) @(negedge clk);
    chk("mid_busy", bus.busy, 0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_nodone", 64'(done_cnt - d0), 0);
    chk("mid_idle", bus.busy, 0);
    start_pass();
    wait_done("after_rst");

    disp(5, 1'b0, 1, 15);
    disp(2, 1'b1, 1, 12);
    repeat (3) @(negedge clk);
    chk("disp_left", dq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
